mem_bus_arbiter: RTL and testbench

- Shares the single ThinPad RAM1 bus between the IF stage (instruction fetch) and the MEM stage (data load/store).
- Also steers MEM accesses at 0xBF00/0xBF01 to the UART, which sits on the same data bus.
- Gives MEM priority. IF is frozen and fed NOP (16'h0800) while a data access owns the bus.
- Sits between the pipeline (IF, MEM) and the top-level SRAM/UART pins; the top level owns the tristate.

---
 rtl/mem_bus_arbiter_pkg.sv | 36 +++
 rtl/mem_bus_arbiter_mem_addr_decode.sv | 16 +
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants, FSM state encoding and address-class payload for the RAM1/UART bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] NOP_INSTR      = 16'h0800;
    localparam logic [DATA_W-1:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [DATA_W-1:0] UART_STAT_ADDR = 16'hBF01;

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_DRD   = 3'd1;
    localparam logic [2:0] ST_DWR1  = 3'd2;
    localparam logic [2:0] ST_DWR2  = 3'd3;
    localparam logic [2:0] ST_URD1  = 3'd4;
    localparam logic [2:0] ST_URD2  = 3'd5;
    localparam logic [2:0] ST_UWR1  = 3'd6;
    localparam logic [2:0] ST_UWR2  = 3'd7;

    typedef enum logic [2:0] {
        FETCH = ST_FETCH,
        DRD   = ST_DRD,
        DWR1  = ST_DWR1,
        DWR2  = ST_DWR2,
        URD1  = ST_URD1,
        URD2  = ST_URD2,
        UWR1  = ST_UWR1,
        UWR2  = ST_UWR2
    } state_t;

    typedef struct packed {
        logic is_ram;
        logic is_uart_data;
        logic is_uart_stat;
    } addr_class_t;

endpackage

// File: rtl/mem_bus_arbiter_mem_addr_decode.sv
// Classifies a MEM-stage word address as RAM, UART data register or UART status register.
module mem_addr_decode
    import mem_bus_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] addr,
    output addr_class_t       addr_class_c
);

    always_comb begin
        addr_class_c              = '0;
        addr_class_c.is_uart_data = (addr == UART_DATA_ADDR);
        addr_class_c.is_uart_stat = (addr == UART_STAT_ADDR);
        addr_class_c.is_ram       = !addr_class_c.is_uart_data && !addr_class_c.is_uart_stat;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the RAM1 bus between instruction fetch and MEM-stage data/UART accesses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   if_pc,
    output logic [DATA_W-1:0]   if_instr,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [DATA_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                stall,
    output logic                pc_hold,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_dq_o,
    output logic                ram_dq_oe,
    input  logic [DATA_W-1:0]   ram_dq_i,
    output logic                ram_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    output logic                uart_rdn,
    output logic                uart_wrn,
    input  logic                uart_data_ready,
    input  logic                uart_tbre,
    input  logic                uart_tsre
);

    state_t      state;
    state_t      state_nxt;
    addr_class_t addr_class;
    logic [7:0]  uart_cap;
    logic        bus_req;

    mem_addr_decode u_decode (
        .addr         (mem_addr),
        .addr_class_c (addr_class)
    );

    // Status-register accesses are served in FETCH and never take the bus.
    assign bus_req = (mem_rd || mem_wr) && (addr_class.is_ram || addr_class.is_uart_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // UART RX byte is sampled while uart_rdn is low and presented in the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_cap <= '0;
        end else if (state == URD1) begin
            uart_cap <= ram_dq_i[7:0];
        end
    end

    always_comb begin
        state_nxt = state;
        if_instr  = NOP_INSTR;
        mem_rdata = '0;
        stall     = 1'b0;
        pc_hold   = 1'b1;
        ram_addr  = ADDR_W'(mem_addr);
        ram_dq_o  = mem_wdata;
        ram_dq_oe = 1'b0;
        ram_ce_n  = 1'b0;
        ram_oe_n  = 1'b1;
        ram_we_n  = 1'b1;
        uart_rdn  = 1'b1;
        uart_wrn  = 1'b1;

        unique case (state)
            FETCH: begin
                ram_addr = ADDR_W'(if_pc);
                ram_oe_n = 1'b0;
                if_instr = ram_dq_i;
                pc_hold  = 1'b0;
                if (mem_rd && addr_class.is_uart_stat) begin
                    mem_rdata = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
                end
                if (bus_req) begin
                    stall   = 1'b1;
                    pc_hold = 1'b1;
                    if (mem_wr) begin
                        state_nxt = addr_class.is_uart_data ? UWR1 : DWR1;
                    end else begin
                        state_nxt = addr_class.is_uart_data ? URD1 : DRD;
                    end
                end
            end
            DRD: begin
                ram_oe_n  = 1'b0;
                mem_rdata = ram_dq_i;
                state_nxt = FETCH;
            end
            DWR1: begin
                ram_dq_oe = 1'b1;
                stall     = 1'b1;
                state_nxt = DWR2;
            end
            DWR2: begin
                ram_dq_oe = 1'b1;
                ram_we_n  = 1'b0;
                state_nxt = FETCH;
            end
            URD1: begin
                ram_ce_n  = 1'b1;
                uart_rdn  = 1'b0;
                stall     = 1'b1;
                state_nxt = URD2;
            end
            URD2: begin
                ram_ce_n  = 1'b1;
                mem_rdata = {8'b0, uart_cap};
                state_nxt = FETCH;
            end
            UWR1: begin
                ram_ce_n  = 1'b1;
                ram_dq_oe = 1'b1;
                uart_wrn  = 1'b0;
                stall     = 1'b1;
                state_nxt = UWR2;
            end
            UWR2: begin
                ram_ce_n  = 1'b1;
                ram_dq_oe = 1'b1;
                state_nxt = FETCH;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a small SRAM/UART environment and reference memory.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [15:0] FETCH_PC  = 16'd1023;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       if_pc;
    logic [15:0]       if_instr;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              stall;
    logic              pc_hold;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_dq_o;
    logic              ram_dq_oe;
    logic [15:0]       ram_dq_i;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic              uart_rdn;
    logic              uart_wrn;
    logic              uart_data_ready;
    logic              uart_tbre;
    logic              uart_tsre;

    logic              sram_mode;
    logic              sram_fill;
    logic [15:0]       dq_drive;
    logic [15:0]       uart_rx;
    logic [15:0]       sram    [MEM_WORDS];
    logic [15:0]       ref_mem [MEM_WORDS];

    int n_pass  = 0;
    int n_total = 0;

    int          op_bub, op_hold, op_rdn, op_wrn, op_wen;
    logic [15:0] op_tx, op_rdata;

    mem_bus_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .stall           (stall),
        .pc_hold         (pc_hold),
        .ram_addr        (ram_addr),
        .ram_dq_o        (ram_dq_o),
        .ram_dq_oe       (ram_dq_oe),
        .ram_dq_i        (ram_dq_i),
        .ram_ce_n        (ram_ce_n),
        .ram_oe_n        (ram_oe_n),
        .ram_we_n        (ram_we_n),
        .uart_rdn        (uart_rdn),
        .uart_wrn        (uart_wrn),
        .uart_data_ready (uart_data_ready),
        .uart_tbre       (uart_tbre),
        .uart_tsre       (uart_tsre)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int i);
        return 16'hA000 | 16'(i);
    endfunction

    // Environment: either a fixed bus value, or an SRAM plus a UART RX register sharing the bus.
    always_comb begin
        if (!sram_mode)                    ram_dq_i = dq_drive;
        else if (!uart_rdn)                ram_dq_i = uart_rx;
        else if (!ram_ce_n && !ram_oe_n)   ram_dq_i = sram[ram_addr[9:0]];
        else                               ram_dq_i = 16'hDEAD;
    end

    always @(posedge clk) begin
        if (sram_fill) begin
            for (int i = 0; i < MEM_WORDS; i++) sram[i] <= pat(i);
        end else if (sram_mode && !ram_ce_n && !ram_we_n && ram_dq_oe) begin
            sram[ram_addr[9:0]] <= ram_dq_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one MEM request until stall drops, tallying what the bus did along the way.
    task automatic run_op(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        bit done = 0;
        op_bub = 0; op_hold = 0; op_rdn = 0; op_wrn = 0; op_wen = 0;
        op_tx = 16'h0; op_rdata = 16'h0;
        mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wdata = wdata;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            chk("bus_excl", 32'(!ram_ce_n && (!uart_rdn || !uart_wrn)), 32'd0);
            chk("dq_oe", 32'(ram_dq_oe), 32'(k > 0 && wr && addr != UART_STAT_ADDR));
            if (if_instr === NOP_INSTR) op_bub++;
            if (pc_hold)   op_hold++;
            if (!uart_rdn) op_rdn++;
            if (!uart_wrn) begin op_wrn++; op_tx = ram_dq_o; end
            if (!ram_we_n) op_wen++;
            if (!stall) begin done = 1; op_rdata = mem_rdata; end
            tick();
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        chk("op_done", 32'(done), 32'd1);
    endtask

    // Reference: bubble/hold cost and strobe counts from the access kind alone.
    task automatic op_check(input string tag, input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] exp_rdata);
        bit is_stat = (addr == UART_STAT_ADDR);
        bit is_uart = (addr == UART_DATA_ADDR);
        bit is_read = rd && !wr;
        int bub     = (is_stat || !(rd || wr)) ? 0 : ((is_read && !is_uart) ? 1 : 2);
        int hold    = (bub == 0) ? 0 : bub + 1;
        run_op(rd, wr, addr, wdata);
        chk({tag, "_bubbles"}, 32'(op_bub), 32'(bub));
        chk({tag, "_pc_hold"}, 32'(op_hold), 32'(hold));
        chk({tag, "_rdn"}, 32'(op_rdn), 32'(is_read && is_uart));
        chk({tag, "_wrn"}, 32'(op_wrn), 32'(wr && is_uart));
        chk({tag, "_wen"}, 32'(op_wen), 32'(wr && !is_uart && !is_stat));
        if (is_read) chk({tag, "_rdata"}, 32'(op_rdata), 32'(exp_rdata));
        if (wr && is_uart) chk({tag, "_tx"}, 32'(op_tx), 32'(wdata));
    endtask

    initial begin
        rst = 1'b0; if_pc = 16'h0; mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 16'h0; mem_wdata = 16'h0;
        uart_data_ready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0;
        sram_mode = 1'b0; sram_fill = 1'b0; dq_drive = 16'h0; uart_rx = 16'h0;

        // reset values
        @(negedge clk);
        chk("rst_we_n", 32'(ram_we_n), 32'd1);
        chk("rst_rdn", 32'(uart_rdn), 32'd1);
        chk("rst_wrn", 32'(uart_wrn), 32'd1);
        chk("rst_dq_oe", 32'(ram_dq_oe), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        tick();

        // idle fetch
        if_pc = 16'h0003; dq_drive = 16'h6901;
        @(negedge clk);
        chk("idle_addr", 32'(ram_addr), 32'h00003);
        chk("idle_instr", 32'(if_instr), 32'h6901);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_hold", 32'(pc_hold), 32'd0);
        chk("idle_ce_oe", 32'({ram_ce_n, ram_oe_n}), 32'd0);
        tick();

        // RAM read
        mem_rd = 1'b1; mem_addr = 16'h1234; dq_drive = 16'h00CF;
        @(negedge clk);
        chk("rd_f_stall", 32'(stall), 32'd1);
        chk("rd_f_hold", 32'(pc_hold), 32'd1);
        tick();
        @(negedge clk);
        chk("rd_addr", 32'(ram_addr), 32'h01234);
        chk("rd_rdata", 32'(mem_rdata), 32'h00CF);
        chk("rd_stall", 32'(stall), 32'd0);
        chk("rd_instr", 32'(if_instr), 32'(NOP_INSTR));
        chk("rd_oe_n", 32'(ram_oe_n), 32'd0);
        tick();
        mem_rd = 1'b0;

        // RAM write: cycle-by-cycle pin check
        mem_wr = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'hCF00;
        @(negedge clk);
        chk("wr_f_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("wr1_pins", 32'({ram_we_n, ram_oe_n, ram_dq_oe, stall, pc_hold}), 32'b11111);
        chk("wr1_bus", 32'({ram_addr[13:0], ram_dq_o}), 32'({14'h0000 | 14'(18'h08000), 16'hCF00}));
        chk("wr1_addr", 32'(ram_addr), 32'h08000);
        chk("wr1_instr", 32'(if_instr), 32'(NOP_INSTR));
        tick();
        @(negedge clk);
        chk("wr2_pins", 32'({ram_we_n, ram_dq_oe, stall, pc_hold}), 32'b0101);
        chk("wr2_addr", 32'(ram_addr), 32'h08000);
        chk("wr2_data", 32'(ram_dq_o), 32'hCF00);
        tick();
        mem_wr = 1'b0;
        op_check("wr_cost", 1'b0, 1'b1, 16'h8000, 16'hCF00, 16'h0);

        // reset asserted inside DWR2
        mem_wr = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h5555;
        tick(); tick();
        @(negedge clk);
        chk("abort_pre_we", 32'(ram_we_n), 32'd0);
        #1 rst = 1'b0; mem_wr = 1'b0;
        #1;
        chk("abort_we_n", 32'(ram_we_n), 32'd1);
        chk("abort_dq_oe", 32'(ram_dq_oe), 32'd0);
        chk("abort_hold", 32'(pc_hold), 32'd0);
        @(negedge clk);
        rst = 1'b1; dq_drive = 16'h1357;
        @(negedge clk);
        chk("abort_instr", 32'(if_instr), 32'h1357);
        chk("abort_addr", 32'(ram_addr), 32'h00003);
        chk("abort_stall", 32'(stall), 32'd0);
        tick();

        // UART write then read
        op_check("uwr", 1'b0, 1'b1, UART_DATA_ADDR, 16'h0041, 16'h0);
        dq_drive = 16'h00AB;
        op_check("urd", 1'b1, 1'b0, UART_DATA_ADDR, 16'h0, 16'h00AB);
        dq_drive = 16'h77CD;
        op_check("urd_hi", 1'b1, 1'b0, UART_DATA_ADDR, 16'h0, 16'h00CD);

        // status register
        uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
        op_check("stat_rd", 1'b1, 1'b0, UART_STAT_ADDR, 16'h0, 16'h0002);
        op_check("stat_wr", 1'b0, 1'b1, UART_STAT_ADDR, 16'hFFFF, 16'h0);
        uart_data_ready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1;
        op_check("stat_rd2", 1'b1, 1'b0, UART_STAT_ADDR, 16'h0, 16'h0001);

        // randomized traffic against a reference memory
        sram_mode = 1'b1; sram_fill = 1'b1; if_pc = FETCH_PC;
        tick();
        sram_fill = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i);
        for (int n = 0; n < 80; n++) begin
            int          kind  = int'($urandom_range(6, 0));
            int          idle  = int'($urandom_range(2, 0));
            logic [15:0] raddr = 16'($urandom_range(MEM_WORDS - 2, 0));
            logic [15:0] wdat  = 16'($urandom);
            uart_rx = 16'($urandom);
            uart_data_ready = 1'($urandom); uart_tbre = 1'($urandom); uart_tsre = 1'($urandom);
            for (int j = 0; j < idle; j++) begin
                @(negedge clk);
                chk("rnd_idle_instr", 32'(if_instr), 32'(ref_mem[FETCH_PC]));
                chk("rnd_idle_stall", 32'({stall, pc_hold}), 32'd0);
                tick();
            end
            case (kind)
                0: op_check("rnd_rd", 1'b1, 1'b0, raddr, wdat, ref_mem[raddr]);
                1: begin op_check("rnd_wr", 1'b0, 1'b1, raddr, wdat, 16'h0); ref_mem[raddr] = wdat; end
                2: op_check("rnd_urd", 1'b1, 1'b0, UART_DATA_ADDR, wdat, {8'h00, uart_rx[7:0]});
                3: op_check("rnd_uwr", 1'b0, 1'b1, UART_DATA_ADDR, wdat, 16'h0);
                4: op_check("rnd_srd", 1'b1, 1'b0, UART_STAT_ADDR, wdat,
                            {14'b0, uart_data_ready, uart_tbre & uart_tsre});
                5: op_check("rnd_swr", 1'b0, 1'b1, UART_STAT_ADDR, wdat, 16'h0);
                default: begin op_check("rnd_rdwr", 1'b1, 1'b1, raddr, wdat, 16'h0); ref_mem[raddr] = wdat; end
            endcase
        end
        for (int a = 0; a < 16; a++) begin
            logic [15:0] ra = 16'($urandom_range(MEM_WORDS - 2, 0));
            op_check("final_rd", 1'b1, 1'b0, ra, 16'h0, ref_mem[ra]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
